hex_token_parser: RTL and testbench
===================================

Name: hex_token_parser

Overview:
Sequential ASCII-to-hex parser. It consumes a stream of ASCII characters, one per handshake, from the PDU UART receive path and assembles whitespace-delimited hex tokens into binary values for the command/debug logic. It is the inverse of the PDU hex-to-ASCII display conversion. It reports illegal characters and tokens that are too long.

Parameters:
HEX_NUM, 8, maximum hex digits per token; out_number is HEX_NUM*4 bits wide.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
clear  input  1  synchronous flush; aborts any token in progress.
in_valid  input  1  in_char is valid.
in_ready  output  1  parser can accept a character this cycle.
in_char  input  8  ASCII character.
out_valid  output  1  a token result is available.
out_ready  input  1  consumer accepts the result.
out_number  output  HEX_NUM*4  parsed value, right-aligned, zero-extended.
out_digits  output  $clog2(HEX_NUM+1)  number of digits in the token.
out_error  output  1  the token was malformed.
out_err_code  output  2  01 = illegal character, 10 = overflow, 00 = no error.

Behaviour:
- A character is accepted on a rising edge where in_valid && in_ready.
- Character classes:
  - '0'..'9' map to 0..9.
  - 'A'..'F' and 'a'..'f' map to 10..15.
  - Separators are 0x20, 0x09, 0x0D and 0x0A.
  - Every other code is illegal.
- States: IDLE, ACCUM, SKIP, OUT. in_ready = 1 in IDLE, ACCUM and SKIP, and 0 in OUT. in_ready is decoded directly from the state register.
- IDLE:
  - Separator: ignored, stays in IDLE.
  - Digit: value = digit, count = 1, go to ACCUM.
  - Illegal character: err_code = 01, go to SKIP.
- ACCUM:
  - Digit with count < HEX_NUM: value = {value[HEX_NUM*4-5:0], digit}, count + 1.
  - Digit with count == HEX_NUM: err_code = 10, go to SKIP.
  - Illegal character: err_code = 01, go to SKIP.
  - Separator: latch out_number = value, out_digits = count, out_error = 0, out_err_code = 00, go to OUT.
- SKIP:
  - Digits and illegal characters are consumed and discarded. The first error code recorded in the token is kept.
  - Separator: out_number = 0, out_digits = 0, out_error = 1, out_err_code = the recorded code, go to OUT.
- OUT:
  - out_valid = 1.
  - out_number, out_digits, out_error and out_err_code stay stable until out_valid && out_ready.
  - On that handshake edge, go to IDLE. out_valid is 0 in the following cycle and in_ready is 1.
- Latency: when the terminating separator is accepted at edge N, out_valid is high in the cycle after edge N. The earliest handshake is at edge N+1.
- All outputs are registered except in_ready.
- clear (evaluated synchronously):
  - Forces IDLE, out_valid = 0, and clears value, count and error code. This applies in any state, including OUT.
  - clear takes priority over a simultaneous character acceptance or output handshake; the character is dropped.
- Reset (rstn low), asynchronous:
  - state = IDLE.
  - out_valid, out_number, out_digits, out_error and out_err_code = 0.
  - Internal value, count and error code = 0.
  - in_ready = 1 while in reset and after release.
  - Reset mid-token discards the token; no output is produced for it.
- A separator-only stream never produces output. Consecutive separators between tokens are ignored.
- A token of exactly HEX_NUM digits is legal. The (HEX_NUM+1)th digit causes overflow.

Test Plan:
1. HEX_NUM=8, send "1aF\r" with out_ready=1 -> one out_valid pulse the cycle after '\r' is accepted; out_number=0x000001AF, out_digits=3, out_error=0.
2. Send "12345678 " -> 0x12345678, out_digits=8, no error. Then send "123456789 " -> out_error=1, out_err_code=10, out_number=0, out_digits=0.
3. Send "  \t\r\n" -> out_valid never asserts and in_ready stays 1 throughout.
4. Send "4G2 " with out_ready held low for 5 cycles -> out_error=1, out_err_code=01; out_valid and all values stay stable and in_ready=0 for the whole hold. After the handshake, send "7 " -> out_number=0x7, out_digits=1, no error.
5. Send "AB", pulse clear in the same cycle as a valid 'C', then send "D " -> the 'C' is dropped; result is 0xD, out_digits=1.
6. Assert rstn low mid-ACCUM after "FF" -> all outputs are 0 immediately and in_ready=1. After release, send "3 " -> out_number=0x3, out_digits=1.

Source files
------------

// File: rtl/hex_token_parser.sv
// ============================================================================
// Module   : hex_token_parser
// Purpose  : Assembles whitespace-delimited ASCII hex tokens into binary values
//            and flags illegal characters and over-long tokens.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_token_parser #(
  parameter int HEX_NUM = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [7:0]                     in_char,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [HEX_NUM*4-1:0]           out_number,
  output logic [$clog2(HEX_NUM+1)-1:0]   out_digits,
  output logic                           out_error,
  output logic [1:0]                     out_err_code
);

  localparam int            W           = HEX_NUM * 4;
  localparam int            CW          = $clog2(HEX_NUM + 1);
  localparam logic [CW-1:0] MAX_CNT     = CW'(HEX_NUM);
  localparam logic [1:0]    ERR_NONE    = 2'b00;
  localparam logic [1:0]    ERR_ILLEGAL = 2'b01;
  localparam logic [1:0]    ERR_OVF     = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SKIP  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t        state_q;
  logic [W-1:0]  value_q;
  logic [CW-1:0] count_q;
  logic [1:0]    err_q;

  logic       is_digit;
  logic       is_sep;
  logic [3:0] digit;
  logic       accept;

  assign in_ready = (state_q != S_OUT);
  assign accept   = in_valid && in_ready;

  // Letters carry their value in the low nibble offset by 9 ('A' = 0x41).
  always_comb begin
    is_digit = 1'b0;
    is_sep   = 1'b0;
    digit    = 4'h0;
    if (in_char >= 8'h30 && in_char <= 8'h39) begin
      is_digit = 1'b1;
      digit    = in_char[3:0];
    end else if ((in_char >= 8'h41 && in_char <= 8'h46) ||
                 (in_char >= 8'h61 && in_char <= 8'h66)) begin
      is_digit = 1'b1;
      digit    = in_char[3:0] + 4'd9;
    end else if (in_char == 8'h20 || in_char == 8'h09 ||
                 in_char == 8'h0D || in_char == 8'h0A) begin
      is_sep = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      value_q      <= '0;
      count_q      <= '0;
      err_q        <= ERR_NONE;
      out_valid    <= 1'b0;
      out_number   <= '0;
      out_digits   <= '0;
      out_error    <= 1'b0;
      out_err_code <= ERR_NONE;
    end else if (clear) begin
      state_q   <= S_IDLE;
      value_q   <= '0;
      count_q   <= '0;
      err_q     <= ERR_NONE;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_digit) begin
              value_q <= W'(digit);
              count_q <= CW'(1);
              state_q <= S_ACCUM;
            end else if (!is_sep) begin
              err_q   <= ERR_ILLEGAL;
              state_q <= S_SKIP;
            end
          end
        end
        S_ACCUM: begin
          if (accept) begin
            if (is_digit) begin
              if (count_q == MAX_CNT) begin
                err_q   <= ERR_OVF;
                state_q <= S_SKIP;
              end else begin
                value_q <= (value_q << 4) | W'(digit);
                count_q <= count_q + CW'(1);
              end
            end else if (is_sep) begin
              out_number   <= value_q;
              out_digits   <= count_q;
              out_error    <= 1'b0;
              out_err_code <= ERR_NONE;
              out_valid    <= 1'b1;
              state_q      <= S_OUT;
            end else begin
              err_q   <= ERR_ILLEGAL;
              state_q <= S_SKIP;
            end
          end
        end
        S_SKIP: begin
          // Only the first error of a token is reported; later ones are swallowed.
          if (accept && is_sep) begin
            out_number   <= '0;
            out_digits   <= '0;
            out_error    <= 1'b1;
            out_err_code <= err_q;
            out_valid    <= 1'b1;
            state_q      <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            value_q   <= '0;
            count_q   <= '0;
            err_q     <= ERR_NONE;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hex_token_parser.sv
// ============================================================================
// Module   : tb_hex_token_parser
// Purpose  : Directed self-checking bench for hex_token_parser (HEX_NUM = 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_token_parser;

  logic        clk;
  logic        rstn;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_char;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_number;
  logic [3:0]  out_digits;
  logic        out_error;
  logic [1:0]  out_err_code;

  int errors = 0;
  int checks = 0;

  hex_token_parser #(.HEX_NUM(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_char      (in_char),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_number   (out_number),
    .out_digits   (out_digits),
    .out_error    (out_error),
    .out_err_code (out_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called 1ns after a rising edge; presents c and returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] c);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_char  = c;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic chk_result(input string tag, input logic [31:0] num, input logic [3:0] dig,
                            input logic err, input logic [1:0] code);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_number"}, out_number, num);
    chk({tag, "_digits"}, 32'(out_digits), 32'(dig));
    chk({tag, "_error"}, 32'(out_error), 32'(err));
    chk({tag, "_code"}, 32'(out_err_code), 32'(code));
  endtask

  initial begin
    rstn      = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_number", out_number, 32'd0);
    chk("rst_digits", 32'(out_digits), 32'd0);
    chk("rst_code", 32'(out_err_code), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1: basic mixed-case token terminated by CR, single-cycle pulse
    send_str("1aF");
    chk("t1_novalid_early", 32'(out_valid), 32'd0);
    send(8'h0D);
    chk("t1_ready_out", 32'(in_ready), 32'd0);
    chk_result("t1", 32'h000001AF, 4'd3, 1'b0, 2'b00);
    @(posedge clk); #1;
    chk("t1_pulse_end", 32'(out_valid), 32'd0);
    chk("t1_ready_back", 32'(in_ready), 32'd1);

    // 2: exactly HEX_NUM digits is legal, one more overflows
    send_str("12345678 ");
    chk_result("t2a", 32'h12345678, 4'd8, 1'b0, 2'b00);
    send_str("123456789 ");
    chk_result("t2b", 32'h0, 4'd0, 1'b1, 2'b10);

    // 3: separators alone never produce output
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      send((i == 0 || i == 1) ? 8'h20 : (i == 2) ? 8'h09 : (i == 3) ? 8'h0D : 8'h0A);
      chk("t3_valid", 32'(out_valid), 32'd0);
      chk("t3_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    chk("t3_valid_after", 32'(out_valid), 32'd0);

    // 4: illegal char, result held while consumer stalls
    out_ready = 1'b0;
    send_str("4G2 ");
    for (int i = 0; i < 5; i++) begin
      chk_result("t4_hold", 32'h0, 4'd0, 1'b1, 2'b01);
      chk("t4_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_released", 32'(out_valid), 32'd0);
    chk("t4_ready_back", 32'(in_ready), 32'd1);
    send_str("7 ");
    chk_result("t4b", 32'h7, 4'd1, 1'b0, 2'b00);
    @(posedge clk); #1;

    // 5: clear beats a simultaneous valid character
    send_str("AB");
    in_valid = 1'b1;
    in_char  = "C";
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("t5_clear_valid", 32'(out_valid), 32'd0);
    send_str("D ");
    chk_result("t5", 32'hD, 4'd1, 1'b0, 2'b00);
    @(posedge clk); #1;

    // 6: asynchronous reset mid-token
    send_str("FF");
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_number", out_number, 32'd0);
    chk("t6_digits", 32'(out_digits), 32'd0);
    chk("t6_error", 32'(out_error), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    send_str("3 ");
    chk_result("t6b", 32'h3, 4'd1, 1'b0, 2'b00);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
